// File: rtl/idli_sqi_m.sv
// idli_sqi_m: quad-SPI (SQI) memory transaction sequencer.
//
// A request in IDLE issues a 2-nibble command (0x03 read / 0x02 write),
// then a 6-nibble address (MS nibble first). Reads insert 2 dummy beats,
// then enter the data phase. The data phase is unbounded and ends on
// i_sqi_stop. Read nibbles come out registered, one cycle after they are
// sampled. Write nibbles pass combinationally from i_sqi_wdata to SIO.
//
// Ports:
//   i_sqi_gck        clock, rising edge
//   i_sqi_rst        synchronous active-high reset
//   i_sqi_req        start transaction (IDLE only)
//   i_sqi_wr         1 = write, 0 = read (sampled with req)
//   i_sqi_addr       24-bit byte address (sampled with req)
//   i_sqi_stop       end burst (DATA only)
//   i_sqi_wdata      write nibble for the current DATA cycle
//   o_sqi_wdata_rdy  i_sqi_wdata consumed this cycle
//   o_sqi_busy       not IDLE
//   o_sqi_cs         chip select, active-high
//   o_sqi_sio_out    nibble driven onto SIO[3:0]
//   o_sqi_sio_oe     per-pin output enable
//   i_sqi_sio_in     nibble read from SIO[3:0]
//   o_sqi_data       registered read nibble
//   o_sqi_data_vld   o_sqi_data valid
//
// state | meaning
// IDLE  | no transaction, CS low, waiting for req
// CMD   | 2 beats of command nibbles
// ADDR  | 6 beats of address nibbles, MS first
// DUMMY | 2 turnaround beats, reads only
// DATA  | data transfer until stop
module idli_sqi_m (
  input  logic        i_sqi_gck,
  input  logic        i_sqi_rst,
  input  logic        i_sqi_req,
  input  logic        i_sqi_wr,
  input  logic [23:0] i_sqi_addr,
  input  logic        i_sqi_stop,
  input  logic [3:0]  i_sqi_wdata,
  output logic        o_sqi_wdata_rdy,
  output logic        o_sqi_busy,
  output logic        o_sqi_cs,
  output logic [3:0]  o_sqi_sio_out,
  output logic [3:0]  o_sqi_sio_oe,
  input  logic [3:0]  i_sqi_sio_in,
  output logic [3:0]  o_sqi_data,
  output logic        o_sqi_data_vld
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CMD   = 3'd1;
  localparam logic [2:0] ST_ADDR  = 3'd2;
  localparam logic [2:0] ST_DUMMY = 3'd3;
  localparam logic [2:0] ST_DATA  = 3'd4;

  logic [2:0]  r_state;
  logic [2:0]  r_beat;
  logic        r_wr;
  logic [23:0] r_addr;
  logic [3:0]  r_data;
  logic        r_data_vld;

  logic [2:0]  w_state_nxt;
  logic        w_rd_data;
  logic        w_wr_data;
  logic [3:0]  w_addr_nib;

  assign w_rd_data = (r_state == ST_DATA) && !r_wr;
  assign w_wr_data = (r_state == ST_DATA) &&  r_wr;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (i_sqi_req)       w_state_nxt = ST_CMD;
      ST_CMD:   if (r_beat == 3'd1)  w_state_nxt = ST_ADDR;
      ST_ADDR:  if (r_beat == 3'd5)  w_state_nxt = r_wr ? ST_DATA : ST_DUMMY;
      ST_DUMMY: if (r_beat == 3'd1)  w_state_nxt = ST_DATA;
      ST_DATA:  if (i_sqi_stop)      w_state_nxt = ST_IDLE;
      default:                       w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_sqi_gck) begin
    if (i_sqi_rst) begin
      r_state    <= ST_IDLE;
      r_beat     <= 3'd0;
      r_wr       <= 1'b0;
      r_addr     <= 24'd0;
      r_data     <= 4'd0;
      r_data_vld <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      // Beat only matters in the fixed-length phases; hold it at 0 elsewhere.
      if (w_state_nxt != r_state)
        r_beat <= 3'd0;
      else if (r_state == ST_CMD || r_state == ST_ADDR || r_state == ST_DUMMY)
        r_beat <= r_beat + 3'd1;
      if (r_state == ST_IDLE && i_sqi_req) begin
        r_wr   <= i_sqi_wr;
        r_addr <= i_sqi_addr;
      end
      // The stop cycle still samples, so its nibble emerges after CS drops.
      r_data_vld <= w_rd_data;
      if (w_rd_data)
        r_data <= i_sqi_sio_in;
    end
  end

  always_comb begin
    w_addr_nib = 4'h0;
    case (r_beat)
      3'd0:    w_addr_nib = r_addr[23:20];
      3'd1:    w_addr_nib = r_addr[19:16];
      3'd2:    w_addr_nib = r_addr[15:12];
      3'd3:    w_addr_nib = r_addr[11:8];
      3'd4:    w_addr_nib = r_addr[7:4];
      3'd5:    w_addr_nib = r_addr[3:0];
      default: w_addr_nib = 4'h0;
    endcase
  end

  always_comb begin
    o_sqi_sio_out = 4'h0;
    case (r_state)
      ST_CMD:  o_sqi_sio_out = (r_beat == 3'd0) ? 4'h0 : (r_wr ? 4'h2 : 4'h3);
      ST_ADDR: o_sqi_sio_out = w_addr_nib;
      ST_DATA: o_sqi_sio_out = r_wr ? i_sqi_wdata : 4'h0;
      default: o_sqi_sio_out = 4'h0;
    endcase
  end

  assign o_sqi_sio_oe    = (r_state == ST_CMD || r_state == ST_ADDR || w_wr_data) ? 4'hF : 4'h0;
  assign o_sqi_busy      = (r_state != ST_IDLE);
  assign o_sqi_cs        = (r_state != ST_IDLE);
  assign o_sqi_wdata_rdy = w_wr_data;
  assign o_sqi_data      = r_data;
  assign o_sqi_data_vld  = r_data_vld;

endmodule

// File: tb/tb_idli_sqi_m.sv
module tb_idli_sqi_m;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        wr;
  logic [23:0] addr;
  logic        stop;
  logic [3:0]  wdata;
  logic        wdata_rdy;
  logic        busy;
  logic        cs;
  logic [3:0]  sio_out;
  logic [3:0]  sio_oe;
  logic [3:0]  sio_in;
  logic [3:0]  data;
  logic        data_vld;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  idli_sqi_m dut (
    .i_sqi_gck       (clk),
    .i_sqi_rst       (rst),
    .i_sqi_req       (req),
    .i_sqi_wr        (wr),
    .i_sqi_addr      (addr),
    .i_sqi_stop      (stop),
    .i_sqi_wdata     (wdata),
    .o_sqi_wdata_rdy (wdata_rdy),
    .o_sqi_busy      (busy),
    .o_sqi_cs        (cs),
    .o_sqi_sio_out   (sio_out),
    .o_sqi_sio_oe    (sio_oe),
    .i_sqi_sio_in    (sio_in),
    .o_sqi_data      (data),
    .o_sqi_data_vld  (data_vld)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Cycles 0..8 of a read; returns at the start of cycle 9 (DUMMY beat 0).
  // With inject set, a write request with a different address is pulsed in ADDR.
  task automatic read_front(input logic [23:0] a, input bit inject);
    logic [3:0] e;
    req = 1'b1; wr = 1'b0; addr = a; stop = 1'b1; sio_in = 4'h0;
    sample();
    chk("c0_busy", busy, 0);
    chk("c0_cs", cs, 0);
    next_cycle();
    stop = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (inject && k == 5) begin
        req = 1'b1; wr = 1'b1; addr = 24'hFFFFFF;
      end else begin
        req = 1'b0; wr = 1'b0; addr = 24'h0;
      end
      sample();
      if (k == 1)      e = 4'h0;
      else if (k == 2) e = 4'h3;
      else             e = 4'((a >> (4 * (8 - k))) & 24'hF);
      chk($sformatf("rd_c%0d_sio_out", k), sio_out, e);
      chk($sformatf("rd_c%0d_oe", k), sio_oe, 4'hF);
      chk($sformatf("rd_c%0d_cs", k), cs, 1);
      next_cycle();
    end
    req = 1'b0; wr = 1'b0; addr = 24'h0;
  endtask

  // Cycles 9..13 of a read, SIO returns 1,2,3, stop on cycle 13.
  // Returns at the start of cycle 14.
  task automatic read_tail();
    stop = 1'b1;
    sample();
    chk("rd_c9_oe", sio_oe, 0);
    chk("rd_c9_cs", cs, 1);
    chk("rd_c9_sio_out", sio_out, 0);
    chk("rd_c9_vld", data_vld, 0);
    next_cycle();
    stop = 1'b0;
    sample();
    chk("rd_c10_oe", sio_oe, 0);
    chk("rd_c10_busy", busy, 1);
    next_cycle();
    sio_in = 4'h1;
    sample();
    chk("rd_c11_vld", data_vld, 0);
    chk("rd_c11_rdy", wdata_rdy, 0);
    chk("rd_c11_oe", sio_oe, 0);
    next_cycle();
    sio_in = 4'h2;
    sample();
    chk("rd_c12_vld", data_vld, 1);
    chk("rd_c12_data", data, 4'h1);
    next_cycle();
    sio_in = 4'h3; stop = 1'b1;
    sample();
    chk("rd_c13_vld", data_vld, 1);
    chk("rd_c13_data", data, 4'h2);
    chk("rd_c13_cs", cs, 1);
    next_cycle();
    stop = 1'b0; sio_in = 4'h0;
  endtask

  initial begin
    logic [3:0] e;
    rst = 1'b1; req = 1'b0; wr = 1'b0; addr = 24'h0; stop = 1'b0;
    wdata = 4'h0; sio_in = 4'h0;
    next_cycle();
    next_cycle();
    sample();
    chk("rst_busy", busy, 0);
    chk("rst_cs", cs, 0);
    chk("rst_oe", sio_oe, 0);
    chk("rst_sio_out", sio_out, 0);
    chk("rst_vld", data_vld, 0);
    chk("rst_data", data, 0);
    next_cycle();
    rst = 1'b0;

    // Read of 0x012345, stop with req in IDLE has no effect on the request.
    read_front(24'h012345, 1'b0);
    read_tail();

    // Cycle 14: last read nibble with CS low; back-to-back write request.
    req = 1'b1; wr = 1'b1; addr = 24'h00ABCD;
    sample();
    chk("rd_c14_vld", data_vld, 1);
    chk("rd_c14_data", data, 4'h3);
    chk("rd_c14_cs", cs, 0);
    chk("rd_c14_busy", busy, 0);
    next_cycle();

    req = 1'b0; wr = 1'b0; addr = 24'h0;
    sample();
    chk("wr_c1_cs", cs, 1);
    chk("wr_c1_sio_out", sio_out, 4'h0);
    chk("wr_c1_vld", data_vld, 0);
    chk("wr_c1_data_hold", data, 4'h3);
    next_cycle();
    sample();
    chk("wr_c2_sio_out", sio_out, 4'h2);
    chk("wr_c2_oe", sio_oe, 4'hF);
    next_cycle();
    for (int k = 3; k <= 8; k++) begin
      sample();
      e = 4'((24'h00ABCD >> (4 * (8 - k))) & 24'hF);
      chk($sformatf("wr_c%0d_sio_out", k), sio_out, e);
      chk($sformatf("wr_c%0d_rdy", k), wdata_rdy, 0);
      next_cycle();
    end
    wdata = 4'h7;
    sample();
    chk("wr_c9_sio_out", sio_out, 4'h7);
    chk("wr_c9_oe", sio_oe, 4'hF);
    chk("wr_c9_rdy", wdata_rdy, 1);
    chk("wr_c9_vld", data_vld, 0);
    next_cycle();
    wdata = 4'h8; stop = 1'b1;
    sample();
    chk("wr_c10_sio_out", sio_out, 4'h8);
    chk("wr_c10_rdy", wdata_rdy, 1);
    chk("wr_c10_cs", cs, 1);
    next_cycle();
    wdata = 4'h0; stop = 1'b0;
    sample();
    chk("wr_c11_cs", cs, 0);
    chk("wr_c11_oe", sio_oe, 0);
    chk("wr_c11_rdy", wdata_rdy, 0);
    chk("wr_c11_busy", busy, 0);
    next_cycle();

    // Read with a request pulsed in ADDR, then reset in DUMMY.
    read_front(24'hABCDEF, 1'b1);
    rst = 1'b1;
    sample();
    chk("inj_c9_oe", sio_oe, 0);
    chk("inj_c9_cs", cs, 1);
    next_cycle();
    rst = 1'b0;
    sample();
    chk("rstd_cs", cs, 0);
    chk("rstd_oe", sio_oe, 0);
    chk("rstd_busy", busy, 0);
    chk("rstd_sio_out", sio_out, 0);
    chk("rstd_data", data, 0);
    next_cycle();

    // Fresh read after the abandoned one.
    read_front(24'h012345, 1'b0);
    read_tail();
    sample();
    chk("rd2_c14_vld", data_vld, 1);
    chk("rd2_c14_data", data, 4'h3);
    chk("rd2_c14_cs", cs, 0);
    next_cycle();

    // Stop on the first read DATA cycle: exactly one nibble.
    read_front(24'h000000, 1'b0);
    next_cycle();
    next_cycle();
    sio_in = 4'h9; stop = 1'b1;
    sample();
    chk("one_c11_vld", data_vld, 0);
    chk("one_c11_cs", cs, 1);
    next_cycle();
    sio_in = 4'h0; stop = 1'b0;
    sample();
    chk("one_c12_vld", data_vld, 1);
    chk("one_c12_data", data, 4'h9);
    chk("one_c12_cs", cs, 0);
    chk("one_c12_busy", busy, 0);
    next_cycle();
    sample();
    chk("one_c13_vld", data_vld, 0);
    chk("one_c13_data", data, 4'h9);
    chk("one_c13_cs", cs, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
